// File: rtl/stereo_gain_scheduler_if.sv
// Sample/volume bus of the stereo gain scheduler: two input FIFOs (FWFT read side),
// two output FIFOs (write side) and the host volume controls.
interface stereo_gain_scheduler_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0] vol_target;
  logic                 vol_load;
  logic [DATA_SIZE-1:0] vol_cur;
  logic                 l_in_empty;
  logic                 l_in_rd_en;
  logic [DATA_SIZE-1:0] l_in_dout;
  logic                 r_in_empty;
  logic                 r_in_rd_en;
  logic [DATA_SIZE-1:0] r_in_dout;
  logic                 l_out_full;
  logic                 l_out_wr_en;
  logic [DATA_SIZE-1:0] l_out_din;
  logic                 r_out_full;
  logic                 r_out_wr_en;
  logic [DATA_SIZE-1:0] r_out_din;
  logic                 busy;

  // The scheduler is the master: it pops the input FIFOs and pushes the output FIFOs.
  modport master (
    input  vol_target, vol_load,
    input  l_in_empty, l_in_dout, r_in_empty, r_in_dout,
    input  l_out_full, r_out_full,
    output vol_cur, l_in_rd_en, r_in_rd_en,
    output l_out_wr_en, l_out_din, r_out_wr_en, r_out_din, busy
  );

  modport slave (
    output vol_target, vol_load,
    output l_in_empty, l_in_dout, r_in_empty, r_in_dout,
    output l_out_full, r_out_full,
    input  vol_cur, l_in_rd_en, r_in_rd_en,
    input  l_out_wr_en, l_out_din, r_out_wr_en, r_out_din, busy
  );
endinterface

// File: rtl/stereo_gain_scheduler.sv
// Shares one signed multiplier between left and right audio channels and ramps the
// volume toward the host target once per stereo pair (on each right-channel write).
module stereo_gain_scheduler #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int RAMP_STEP = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  stereo_gain_scheduler_if.master bus
);
  localparam int PW = 2 * DATA_SIZE;
  localparam logic signed [DATA_SIZE-1:0] UNITY   = DATA_SIZE'(1 << BITS);
  localparam logic signed [DATA_SIZE-1:0] STEP_V  = DATA_SIZE'(RAMP_STEP);
  localparam logic signed [DATA_SIZE:0]   STEP_W  = (DATA_SIZE + 1)'(RAMP_STEP);
  localparam logic signed [DATA_SIZE:0]   NSTEP_W = -STEP_W;
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  logic                        ptr;
  logic                        ch;
  logic signed [DATA_SIZE-1:0] x;
  logic signed [DATA_SIZE-1:0] vol;
  logic signed [DATA_SIZE-1:0] vol_tgt;
  logic signed [DATA_SIZE-1:0] vol_ramp;
  logic signed [DATA_SIZE:0]   diff;
  logic signed [PW-1:0]        prod;
  logic                        prod_unused;
  logic                        l_elig, r_elig, grant_l, grant_r;

  assign l_elig = !bus.l_in_empty && !bus.l_out_full;
  assign r_elig = !bus.r_in_empty && !bus.r_out_full;

  // The pointer only breaks ties; a lone eligible channel is always served.
  assign grant_l = (state == S_IDLE) && l_elig && (!r_elig || ptr == LEFT);
  assign grant_r = (state == S_IDLE) && r_elig && (!l_elig || ptr == RIGHT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_l || grant_r) state_next = S_MUL;
      S_MUL:   state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.l_in_rd_en  = grant_l;
    bus.r_in_rd_en  = grant_r;
    bus.l_out_wr_en = 1'b0;
    bus.r_out_wr_en = 1'b0;
    bus.busy        = (state != S_IDLE);
    if (state == S_WRITE) begin
      bus.l_out_wr_en = (ch == LEFT);
      bus.r_out_wr_en = (ch == RIGHT);
    end
  end

  // Difference is one bit wider so opposite-sign extremes cannot wrap.
  assign diff = (DATA_SIZE + 1)'(vol_tgt) - (DATA_SIZE + 1)'(vol);

  always_comb begin
    if (diff > STEP_W)       vol_ramp = vol + STEP_V;
    else if (diff < NSTEP_W) vol_ramp = vol - STEP_V;
    else                     vol_ramp = vol_tgt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x       <= '0;
      ch      <= LEFT;
      prod    <= '0;
      ptr     <= LEFT;
      vol     <= UNITY;
      vol_tgt <= UNITY;
    end else begin
      if (bus.vol_load) vol_tgt <= bus.vol_target;
      if (grant_l) begin
        x  <= bus.l_in_dout;
        ch <= LEFT;
      end else if (grant_r) begin
        x  <= bus.r_in_dout;
        ch <= RIGHT;
      end
      if (state == S_MUL) prod <= PW'(x) * PW'(vol);
      if (state == S_WRITE) begin
        ptr <= ~ch;
        if (ch == RIGHT) vol <= vol_ramp;
      end
    end
  end

  // Taking bits [BITS +: DATA_SIZE] is the floor shift by BITS, truncated without saturation.
  assign bus.l_out_din = prod[BITS +: DATA_SIZE];
  assign bus.r_out_din = prod[BITS +: DATA_SIZE];
  assign bus.vol_cur   = vol;
  assign prod_unused   = ^{prod[PW-1:BITS+DATA_SIZE], prod[BITS-1:0]};
endmodule

// File: tb/tb_stereo_gain_scheduler.sv
// Directed bench for stereo_gain_scheduler: FIFO models on both sides, a vector table
// for gain/ramp cases and hand-written sequences for starvation, backpressure and reset.
module tb_stereo_gain_scheduler;
  logic clock;
  logic reset;

  stereo_gain_scheduler_if #(.DATA_SIZE(32)) bus ();

  stereo_gain_scheduler #(.DATA_SIZE(32), .BITS(10), .RAMP_STEP(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          ch;
    logic [31:0] data;
    int          cyc;
  } out_t;

  typedef struct {
    logic [31:0] vol;
    int          pairs;
    logic [31:0] l_in;
    logic [31:0] r_in;
    logic [31:0] l_exp;
    logic [31:0] r_exp;
  } vec_t;

  out_t        outq[$];
  logic [31:0] lq[$], rq[$];
  int          lrd_cyc[$], rrd_cyc[$];
  int          cyc, n_lrd, n_rrd, n_lwr, n_rwr;
  int          both_rd_err, lat_err, vol_err;
  bit          vol_chk_en;
  int          n_cmp, n_fail;
  logic signed [31:0] model_vol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // FIFO models: sample strobes at negedge, apply pops/pushes 3 time units after posedge.
  initial begin
    logic        s_lrd, s_rrd, s_lwr, s_rwr;
    logic [31:0] s_ld, s_rd, s_vol;
    int          t;
    cyc = 0; n_lrd = 0; n_rrd = 0; n_lwr = 0; n_rwr = 0;
    both_rd_err = 0; lat_err = 0; vol_err = 0;
    bus.l_in_empty = 1'b1; bus.l_in_dout = '0;
    bus.r_in_empty = 1'b1; bus.r_in_dout = '0;
    forever begin
      @(negedge clock);
      s_lrd = bus.l_in_rd_en;  s_rrd = bus.r_in_rd_en;
      s_lwr = bus.l_out_wr_en; s_rwr = bus.r_out_wr_en;
      s_ld  = bus.l_out_din;   s_rd  = bus.r_out_din;
      s_vol = bus.vol_cur;
      @(posedge clock);
      #3;
      if (s_lrd && s_rrd) both_rd_err++;
      if (s_lrd) begin
        n_lrd++; lrd_cyc.push_back(cyc);
        if (lq.size() > 0) void'(lq.pop_front());
      end
      if (s_rrd) begin
        n_rrd++; rrd_cyc.push_back(cyc);
        if (rq.size() > 0) void'(rq.pop_front());
      end
      if (s_lwr) begin
        n_lwr++; outq.push_back('{1'b0, s_ld, cyc});
        t = (lrd_cyc.size() > 0) ? lrd_cyc.pop_front() : -100;
        if (cyc - t != 2) lat_err++;
      end
      if (s_rwr) begin
        n_rwr++; outq.push_back('{1'b1, s_rd, cyc});
        t = (rrd_cyc.size() > 0) ? rrd_cyc.pop_front() : -100;
        if (cyc - t != 2) lat_err++;
      end
      if (vol_chk_en && bus.vol_cur !== s_vol && !s_rwr) vol_err++;
      cyc++;
      bus.l_in_empty = (lq.size() == 0);
      bus.l_in_dout  = (lq.size() > 0) ? lq[0] : 32'h0;
      bus.r_in_empty = (rq.size() == 0);
      bus.r_in_dout  = (rq.size() > 0) ? rq[0] : 32'h0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_outs(input int n, input int bound);
    for (int i = 0; i < bound && outq.size() < n; i++) tick();
  endtask

  task automatic load_target(input logic [31:0] tgt);
    bus.vol_target = tgt;
    bus.vol_load   = 1'b1;
    tick();
    bus.vol_load   = 1'b0;
  endtask

  // Feeds dummy pairs until the volume reaches the target, checking every ramp step.
  task automatic set_volume(input logic [31:0] tgt, input int exp_pairs);
    int     pairs;
    longint d;
    load_target(tgt);
    pairs = 0;
    while (model_vol !== $signed(tgt) && pairs < exp_pairs + 4) begin
      lq.push_back(32'h400); rq.push_back(32'h400);
      wait_outs(2, 30);
      check("ramp_pair_outputs", 32'(outq.size()), 32'd2);
      outq.delete();
      d = longint'($signed(tgt)) - longint'(model_vol);
      if (d > 16)       model_vol = model_vol + 32'sd16;
      else if (d < -16) model_vol = model_vol - 32'sd16;
      else              model_vol = $signed(tgt);
      pairs++;
      check("ramp_vol", bus.vol_cur, model_vol);
    end
    check("ramp_pairs", 32'(pairs), 32'(exp_pairs));
    $display("volume -> %0d after %0d pairs", $signed(bus.vol_cur), pairs);
  endtask

  initial begin
    vec_t        vecs[9];
    int          bad_ch, bad_data, bad_gap, base, first_l;
    logic [31:0] got_l, got_r, exp_d;
    bit          got;

    vecs[0] = '{32'd1024,       0, 32'h00000400, 32'hFFFFFC00, 32'h00000400, 32'hFFFFFC00};
    vecs[1] = '{32'd1024,       0, 32'h12345678, 32'h87654321, 32'h12345678, 32'h87654321};
    vecs[2] = '{32'd512,       32, 32'h00000401, 32'hFFFFFBFF, 32'h00000200, 32'hFFFFFDFF};
    vecs[3] = '{32'd512,        0, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF, 32'hC0000000};
    vecs[4] = '{32'hFFFFFC00,  96, 32'h00000100, 32'hFFFFFF00, 32'hFFFFFF00, 32'h00000100};
    vecs[5] = '{32'hFFFFFC00,   0, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000};
    vecs[6] = '{32'd1536,     160, 32'h00000100, 32'hFFFFFFFF, 32'h00000180, 32'hFFFFFFFE};
    vecs[7] = '{32'd0,         96, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[8] = '{32'd1030,      65, 32'h00000400, 32'hFFFFFC00, 32'h00000406, 32'hFFFFFBFA};

    n_cmp = 0; n_fail = 0;
    vol_chk_en = 1'b0;
    model_vol  = 32'sd1024;
    reset = 1'b0;
    bus.vol_target = '0; bus.vol_load = 1'b0;
    bus.l_out_full = 1'b0; bus.r_out_full = 1'b0;
    repeat (3) tick();
    check("reset_vol_cur", bus.vol_cur, 32'd1024);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_wr_en", {30'd0, bus.l_out_wr_en, bus.r_out_wr_en}, 32'd0);
    check("reset_l_din", bus.l_out_din, 32'd0);
    check("reset_r_din", bus.r_out_din, 32'd0);
    reset = 1'b1;
    tick();
    vol_chk_en = 1'b1;

    // Unity-gain stream: bit-exact, strict L/R alternation, one sample every 3 cycles.
    for (int i = 0; i < 1000; i++) begin
      lq.push_back(32'h400 + 32'(i));
      rq.push_back(32'hFFFFFC00 - 32'(i));
    end
    wait_outs(2000, 6200);
    check("stream_count", 32'(outq.size()), 32'd2000);
    bad_ch = 0; bad_data = 0; bad_gap = 0;
    for (int k = 0; k < outq.size(); k++) begin
      exp_d = (k % 2 == 0) ? 32'h400 + 32'(k / 2) : 32'hFFFFFC00 - 32'(k / 2);
      if (outq[k].ch != bit'(k % 2)) bad_ch++;
      if (outq[k].data !== exp_d) bad_data++;
      if (k > 0 && outq[k].cyc - outq[k-1].cyc != 3) bad_gap++;
    end
    check("stream_alternation_errors", 32'(bad_ch), 32'd0);
    check("stream_data_errors", 32'(bad_data), 32'd0);
    check("stream_spacing_errors", 32'(bad_gap), 32'd0);
    $display("unity stream: %0d samples", outq.size());
    outq.delete();

    foreach (vecs[v]) begin
      set_volume(vecs[v].vol, vecs[v].pairs);
      lq.push_back(vecs[v].l_in); rq.push_back(vecs[v].r_in);
      wait_outs(2, 30);
      check("vec_outputs", 32'(outq.size()), 32'd2);
      got_l = 32'hDEADBEEF; got_r = 32'hDEADBEEF;
      foreach (outq[k]) begin
        if (outq[k].ch) got_r = outq[k].data;
        else            got_l = outq[k].data;
      end
      check($sformatf("vec%0d_left", v), got_l, vecs[v].l_exp);
      check($sformatf("vec%0d_right", v), got_r, vecs[v].r_exp);
      check($sformatf("vec%0d_vol", v), bus.vol_cur, vecs[v].vol);
      $display("vec %0d: vol=%0d L 0x%08h->0x%08h R 0x%08h->0x%08h", v, $signed(vecs[v].vol),
               vecs[v].l_in, got_l, vecs[v].r_in, got_r);
      outq.delete();
    end

    // Right starved: left served every 3 cycles, no right pop, pending target not applied.
    load_target(32'd2048);
    base = n_rrd;
    for (int i = 0; i < 10; i++) lq.push_back(32'h00000800 + 32'(i));
    wait_outs(10, 45);
    check("starve_count", 32'(outq.size()), 32'd10);
    bad_ch = 0; bad_gap = 0;
    for (int k = 0; k < outq.size(); k++) begin
      if (outq[k].ch != 1'b0) bad_ch++;
      if (k > 0 && outq[k].cyc - outq[k-1].cyc != 3) bad_gap++;
    end
    check("starve_channel_errors", 32'(bad_ch), 32'd0);
    check("starve_spacing_errors", 32'(bad_gap), 32'd0);
    check("starve_no_right_pop", 32'(n_rrd - base), 32'd0);
    check("starve_vol_held", bus.vol_cur, 32'd1030);
    $display("right starved: %0d left samples", outq.size());
    outq.delete();
    set_volume(32'd1024, 1);

    // Left output full for 20 cycles: only right served; left takes the first idle slot after.
    bus.l_out_full = 1'b1;
    base = n_rwr;
    first_l = n_lrd;
    for (int i = 0; i < 10; i++) begin
      lq.push_back(32'h100 + 32'(i)); rq.push_back(32'h200 + 32'(i));
    end
    repeat (20) tick();
    check("full_no_left_pop", 32'(n_lrd - first_l), 32'd0);
    check("full_no_left_write", 32'(n_lwr), 32'(n_lwr - (outq.size() - (n_rwr - base))));
    check("full_right_writes", 32'(n_rwr - base >= 6 && n_rwr - base <= 7), 32'd1);
    bus.l_out_full = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.l_in_rd_en || bus.r_in_rd_en) begin
        got = 1'b1;
        check("full_resume_left", {31'd0, bus.l_in_rd_en}, 32'd1);
        break;
      end
    end
    check("full_resume_seen", 32'(got), 32'd1);
    tick();
    for (int i = 0; i < 100 && (lq.size() > 0 || rq.size() > 0 || bus.busy); i++) tick();
    check("full_drained", 32'(lq.size() + rq.size()), 32'd0);
    $display("left backpressure: %0d right writes while full", n_rwr - base);
    outq.delete();

    // Reset while a right sample sits in S_MUL: sample dropped, volume and pointer restored.
    set_volume(32'd512, 32);
    lq.push_back(32'h400);
    wait_outs(1, 20);
    outq.delete();
    rq.push_back(32'h400);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.r_in_rd_en) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_grant_seen", 32'(got), 32'd1);
    @(posedge clock);
    #2;
    base = n_rwr;
    vol_chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_vol_cur", bus.vol_cur, 32'd1024);
    repeat (2) tick();
    check("abort_no_write", 32'(n_rwr - base), 32'd0);
    check("abort_l_din", bus.l_out_din, 32'd0);
    check("abort_r_din", bus.r_out_din, 32'd0);
    reset = 1'b1;
    lrd_cyc.delete(); rrd_cyc.delete(); outq.delete();
    model_vol = 32'sd1024;
    tick();
    vol_chk_en = 1'b1;
    lq.push_back(32'h00000100); rq.push_back(32'h00000300);
    wait_outs(2, 30);
    check("abort_after_outputs", 32'(outq.size()), 32'd2);
    if (outq.size() > 0) begin
      check("abort_first_is_left", 32'(outq[0].ch), 32'd0);
      check("abort_first_data", outq[0].data, 32'h00000100);
    end
    $display("reset in S_MUL: dropped right sample, vol=%0d", $signed(bus.vol_cur));

    check("never_both_rd_en", 32'(both_rd_err), 32'd0);
    check("rd_to_wr_latency_errors", 32'(lat_err), 32'd0);
    check("vol_change_outside_right_write", 32'(vol_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
